dmem_arbiter: RTL

//  Two-requester arbiter in front of the single-port data memory.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arbiter_rr_pick2.sv | 25 ++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, requester id and
// the requester count.
package dmem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;
    typedef logic req_id_t;

    localparam int NUM_REQ = 2;

    function automatic arb_state_t own_state(req_id_t id);
        return id ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a single requester wins outright,
// a tie goes to whichever requester did not own the memory last.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_owner,
    output logic [NUM_REQ-1:0] gnt,
    output logic               id
);

    always_comb begin
        id  = 1'b0;
        gnt = '0;
        if (valid == 2'b11) begin
            id = ~last_owner;
        end else if (valid[1]) begin
            id = 1'b1;
        end
        if (|valid) begin
            gnt[id] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: round-robin
// grant with burst lock, address range check and a registered response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_last,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    req_id_t          last_owner;
    logic [CNT_W-1:0] count;

    logic [1:0]        pick_gnt;
    req_id_t           pick_id;
    logic [1:0]        gnt;
    req_id_t           id;
    logic              accept;
    logic              in_range;
    logic              beat_we;
    logic              burst_end;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_wdata;

    rr_pick2 u_pick (
        .valid      (req_valid),
        .last_owner (last_owner),
        .gnt        (pick_gnt),
        .id         (pick_id)
    );

    // While a burst owns the memory only its requester can be served.
    always_comb begin
        id  = pick_id;
        gnt = pick_gnt;
        case (state)
            ARB_OWN0: begin
                id  = 1'b0;
                gnt = {1'b0, req_valid[0]};
            end
            ARB_OWN1: begin
                id  = 1'b1;
                gnt = {req_valid[1], 1'b0};
            end
            default: ;
        endcase
        if (rst) begin
            gnt = '0;
        end
    end

    assign accept     = |gnt;
    assign beat_addr  = id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign beat_wdata = id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign beat_we    = req_we[id];
    assign in_range   = beat_addr < DEPTH_A;
    assign burst_end  = req_last[id] || (count == FINAL_CNT);

    assign req_ready  = gnt;
    assign mem_addr   = accept ? beat_addr : '0;
    assign mem_wdata  = accept ? beat_wdata : '0;
    assign mem_write  = accept && in_range && beat_we;
    assign mem_read   = accept && in_range && !beat_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_owner <= 1'b1;
            count      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= gnt;
            rsp_err   <= accept && !in_range;
            rsp_rdata <= mem_read ? mem_rdata : '0;
            if (accept) begin
                if (burst_end) begin
                    state      <= ARB_IDLE;
                    last_owner <= id;
                    count      <= '0;
                end else begin
                    state <= own_state(id);
                    count <= count + CNT_W'(1);
                end
            end else if (state != ARB_IDLE) begin
                // Owner went quiet: release after a one-cycle bubble.
                state      <= ARB_IDLE;
                last_owner <= (state == ARB_OWN1);
                count      <= '0;
            end
        end
    end

endmodule
